fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register, sitting directly upstream of the decode stage. It owns the 12-bit program counter and drives the instruction-memory address. It latches the fetched instruction and its PC into the IF/ID register and delivers them to decode as `inst_D`/`pcD`. It also handles branch redirect from decode, pipeline stall, and halt.

---
 rtl/fetch_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, handles branch flush, stall and halt on a sentinel encoding.
module fetch_stage #(
  parameter int unsigned          PC_W      = 12,
  parameter int unsigned          INST_W    = 16,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter logic [INST_W-1:0]    HALT_INST = '1,
  parameter logic [INST_W-1:0]    NOP_INST  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   PC_branch,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst_D,
  output logic [PC_W-1:0]   pcD,
  output logic              valid_D,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalt} state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INST_W-1:0]   if_inst_q, if_inst_d;
  logic [PC_W-1:0]     if_pc_q, if_pc_d;
  logic                if_valid_q, if_valid_d;
  logic                halted_q, halted_d;
  logic                halt_first_q, halt_first_d;
  logic [15:0]         cnt_q, cnt_d;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_inst_d    = if_inst_q;
    if_pc_d      = if_pc_q;
    if_valid_d   = if_valid_q;
    halted_d     = halted_q;
    halt_first_d = 1'b0;
    cnt_d        = cnt_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (branch_taken) begin
          // Flush: the instruction fetched this cycle is wrong-path.
          pc_d       = PC_branch;
          if_inst_d  = NOP_INST;
          if_valid_d = 1'b0;
        end else if (!stall) begin
          if_inst_d  = imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (imem_rdata == HALT_INST) begin
            state_d      = StHalt;
            halted_d     = 1'b1;
            halt_first_d = 1'b1;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      StHalt: begin
        // A stall on the first halt cycle keeps the halt visible to decode.
        if (!(halt_first_q && stall)) begin
          if_inst_d  = NOP_INST;
          if_valid_d = 1'b0;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StBoot;
      pc_q         <= RESET_PC;
      if_inst_q    <= NOP_INST;
      if_pc_q      <= '0;
      if_valid_q   <= 1'b0;
      halted_q     <= 1'b0;
      halt_first_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_inst_q    <= if_inst_d;
      if_pc_q      <= if_pc_d;
      if_valid_q   <= if_valid_d;
      halted_q     <= halted_d;
      halt_first_q <= halt_first_d;
      cnt_q        <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign inst_D      = if_inst_q;
  assign pcD         = if_pc_q;
  assign valid_D     = if_valid_q;
  assign halted      = halted_q;
  assign fetch_count = cnt_q;

endmodule
